sdram_write_cache: RTL
======================

# sdram_write_cache

Write-data cache between the user write port and the SDRAM write stage. Buffers incoming user words in a synchronous FIFO and raises `write_ready` once a full SDRAM burst is stored. On the write stage's `burst_start` pulse, it streams exactly one burst of words out on consecutive cycles, flagging the last beat. It is the block that drives `write_ready` into the SDRAM write stage and supplies the burst data that stage puts on the DQ bus.

## Interface
- `DATA_W`, 16, width of a user/SDRAM data word.
- `DEPTH`, 16, FIFO depth in words; power of 2, ≥ 2·`BURST_LEN`.
- `BURST_LEN`, 4, words per SDRAM write burst; power of 2, ≥ 2.

- `sysclk_100M`  in  1  system clock, 100 MHz, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  user write strobe, one word per cycle.
- `wr_data`  in  `DATA_W`  user write word.
- `full`  out  1  FIFO holds `DEPTH` words.
- `overflow`  out  1  sticky: a write was dropped because the FIFO was full.
- `write_ready`  out  1  at least `BURST_LEN` words are stored and no burst is in progress.
- `burst_start`  in  1  one-cycle pulse from the SDRAM write stage requesting one burst.
- `sdram_wdata`  out  `DATA_W`  burst data word.
- `wdata_valid`  out  1  `sdram_wdata` is valid this cycle.
- `burst_last`  out  1  current beat is the final beat of the burst.
- `word_count`  out  clog2(`DEPTH`)+1  number of words stored.

## Operation
- Storage is a `DEPTH`×`DATA_W` memory with `wr_ptr` and `rd_ptr`, each clog2(`DEPTH`) bits, wrapping naturally modulo `DEPTH`.
- `word_count` is a register.
- **Write side:**
  - A write is accepted when `wr_en`=1 and `full`=0. The accepted write stores `wr_data` at `wr_ptr` and increments `wr_ptr`.
  - When `wr_en`=1 and `full`=1, the word is dropped, `overflow` is set, and it stays set until reset. The word is dropped even if a pop occurs in the same cycle.
- **Burst FSM, two states:**
  - IDLE. `burst_start` is accepted only when state is IDLE and `word_count` ≥ `BURST_LEN`. Otherwise it is ignored, with no side effects.
  - BURST. A beat counter `beat` runs 0..`BURST_LEN`-1.
  - Acceptance in cycle T:
    - Pop the word at `rd_ptr` in T.
    - Enter BURST with `beat`=1.
    - Pop one word per cycle while `beat` < `BURST_LEN`, incrementing `beat`.
    - The pop made while `beat`=`BURST_LEN`-1 is the final one.
    - Return to IDLE in the following cycle.
  - Exactly `BURST_LEN` pops occur, in cycles T..T+`BURST_LEN`-1.
  - A burst cannot be aborted.
  - `burst_start` arriving during BURST is ignored.
- **Pop:** registers mem[`rd_ptr`] into `sdram_wdata`, sets `wdata_valid` for the next cycle, and increments `rd_ptr`.
- **Count update:** `word_count` changes by +1 per accepted write and −1 per pop. A simultaneous accepted write and pop leaves it unchanged.
- **Underflow:** cannot occur, because acceptance guarantees ≥ `BURST_LEN` words. No underflow logic is required.
- **Derived flags:** `full` = (`word_count`==`DEPTH`). `write_ready` = (state==IDLE) && (`word_count` ≥ `BURST_LEN`). Both are decoded from registers only, with no combinational path from inputs.

## Timing
- **Reset values:** `full`=0, `overflow`=0, `write_ready`=0, `sdram_wdata`=0, `wdata_valid`=0, `burst_last`=0, `word_count`=0. Pointers are 0 and state is IDLE.
- **Reset mid-burst:** returns everything to reset values immediately. Remaining beats are lost.
- **Write latency:** a word accepted in cycle N is counted in `word_count` from N+1.
- **`write_ready` rise:** `write_ready` rises in the cycle after the `BURST_LEN`-th stored word is written.
- **Burst timing, accepted `burst_start` in cycle T:**
  - `wdata_valid`=1 in cycles T+1..T+`BURST_LEN`, carrying words in FIFO order.
  - `burst_last`=1 only in T+`BURST_LEN`.
  - `write_ready`=0 from T+1 through T+`BURST_LEN`-1 at least.
  - State is IDLE at T+`BURST_LEN`. `write_ready` may be 1 there if ≥ `BURST_LEN` words remain, so back-to-back bursts are possible with `burst_start` at T+`BURST_LEN`.
- **Minimum spacing:** between accepted `burst_start` pulses is `BURST_LEN` cycles.
- **`sdram_wdata` hold:** `sdram_wdata` holds its last value when `wdata_valid`=0.

## Test plan
- **Reset, fill, single burst:**
  - Stimulus: reset, then write 0x1000..0x1003 on 4 consecutive cycles.
  - Required: `write_ready`=1 one cycle after the 4th write.
  - Stimulus: pulse `burst_start`.
  - Required: `wdata_valid` for 4 cycles with 0x1000..0x1003, `burst_last` on the 4th beat, `word_count` back to 0, `write_ready`=0.
- **Burst request while short:**
  - Stimulus: 3 words stored, then `burst_start`.
  - Required: ignored, `wdata_valid` stays 0, `word_count`=3.
- **Full and overflow:**
  - Stimulus: write 17 words with no bursts.
  - Required: `full`=1 after the 16th, the 17th word is dropped, `overflow`=1 and stays 1.
  - Stimulus: run 4 bursts.
  - Required: the first 16 words come out in order, and the dropped word never appears.
- **Back-to-back bursts with concurrent writes:**
  - Stimulus: 8 words stored; `burst_start` at T and T+4 while writing continuously.
  - Required: 8 consecutive valid beats in order, `word_count` constant during overlap, and `burst_start` at T+2 ignored.
- **Pointer wrap-around:**
  - Stimulus: stream 40 words through with bursts interleaved.
  - Required: output sequence equals input sequence.
- **Reset mid-burst:**
  - Stimulus: assert `rst_n`=0 at beat 2.
  - Required: all outputs 0 asynchronously; after release, `word_count`=0 and `write_ready`=0.

Source files
------------

// File: rtl/sdram_write_cache.sv
// Write-data cache: buffers user words in a FIFO and streams fixed-length bursts
// to the SDRAM write stage on request.
module sdram_write_cache #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                     sysclk_100M,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     overflow,
  output logic                     write_ready,
  input  logic                     burst_start,
  output logic [DATA_W-1:0]        sdram_wdata,
  output logic                     wdata_valid,
  output logic                     burst_last,
  output logic [$clog2(DEPTH):0]   word_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BURST_LEN);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   BURST_C   = (AW+1)'(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q;
  logic [BW-1:0]     beat_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              ovf_q;
  logic [DATA_W-1:0] wdata_q;
  logic              valid_q;
  logic              last_q;

  logic wr_acc;
  logic accept;
  logic pop;
  logic last_pop;

  always_comb begin
    wr_acc   = wr_en && (count_q != DEPTH_C);
    accept   = (state_q == IDLE) && burst_start && (count_q >= BURST_C);
    pop      = accept || (state_q == BURST);
    last_pop = (state_q == BURST) && (beat_q == LAST_BEAT);
    count_d  = count_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset; only the pointers and count define its contents.
  always_ff @(posedge sysclk_100M) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      wdata_q  <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= pop;
      last_q  <= last_pop;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (wr_en && !wr_acc) ovf_q <= 1'b1;
      if (pop) begin
        wdata_q  <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= BURST;
            beat_q  <= BW'(1);
          end
        end
        BURST: begin
          if (last_pop) begin
            state_q <= IDLE;
            beat_q  <= '0;
          end else begin
            beat_q  <= beat_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign full        = (count_q == DEPTH_C);
  assign write_ready = (state_q == IDLE) && (count_q >= BURST_C);
  assign overflow    = ovf_q;
  assign sdram_wdata = wdata_q;
  assign wdata_valid = valid_q;
  assign burst_last  = last_q;
  assign word_count  = count_q;

endmodule
